// File: rtl/int_issue_queue.sv
// rtl/int_issue_queue.sv - integer/branch issue queue, oldest-ready select; INT_ISSUE_QUEUE_PERF_EN adds perf counters
module int_issue_queue #(
    parameter int DEPTH      = 8,
    parameter int IN_WIDTH   = 4,
    parameter int OUT_WIDTH  = 2,
    parameter int WB_WIDTH   = 4,
    parameter int PREG_WIDTH = 7,
    parameter int ROB_WIDTH  = 6,
    parameter int DATA_WIDTH = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [IN_WIDTH-1:0]                 dis_en,
    input  logic [IN_WIDTH*DATA_WIDTH-1:0]      dis_data,
    input  logic [IN_WIDTH*PREG_WIDTH-1:0]      dis_rs1,
    input  logic [IN_WIDTH*PREG_WIDTH-1:0]      dis_rs2,
    input  logic [IN_WIDTH-1:0]                 dis_rs1v,
    input  logic [IN_WIDTH-1:0]                 dis_rs2v,
    input  logic [IN_WIDTH*PREG_WIDTH-1:0]      dis_prd,
    input  logic [IN_WIDTH*(ROB_WIDTH+1)-1:0]   dis_rob,
    output logic                                full,
    input  logic [WB_WIDTH-1:0]                 wb_en,
    input  logic [WB_WIDTH*PREG_WIDTH-1:0]      wb_prd,
    output logic [OUT_WIDTH-1:0]                iss_en,
    output logic [OUT_WIDTH*DATA_WIDTH-1:0]     iss_data,
    output logic [OUT_WIDTH*PREG_WIDTH-1:0]     iss_prd,
    output logic [OUT_WIDTH*(ROB_WIDTH+1)-1:0]  iss_rob,
    input  logic [OUT_WIDTH-1:0]                fu_ready,
    input  logic                                redirect,
    input  logic [ROB_WIDTH:0]                  redirect_rob
`ifdef INT_ISSUE_QUEUE_PERF_EN
    ,
    output logic [31:0]                         perf_full_cycles,
    output logic [31:0]                         perf_issue_cnt
`endif
);
    localparam int RW = ROB_WIDTH + 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;

    logic [DEPTH-1:0]      e_valid, e_r1, e_r2;
    logic [DATA_WIDTH-1:0] e_data [DEPTH];
    logic [PREG_WIDTH-1:0] e_rs1  [DEPTH];
    logic [PREG_WIDTH-1:0] e_rs2  [DEPTH];
    logic [PREG_WIDTH-1:0] e_prd  [DEPTH];
    logic [RW-1:0]         e_rob  [DEPTH];
    logic [CW-1:0]         count;

    logic                  accept;
    logic [DEPTH-1:0]      alloc_hit;
    logic [PW-1:0]         alloc_port [DEPTH];
    logic [DEPTH-1:0]      rdy, iss_mask, nxt_valid;
    logic [CW-1:0]         rank [DEPTH];
    logic [CW-1:0]         nxt_count;
    logic [OUT_WIDTH-1:0]  sel_v;
    logic [SW-1:0]         sel_i [OUT_WIDTH];

    // a is older than b; the dir bit flips on every ROB wrap
    function automatic logic older(input logic [RW-1:0] a, input logic [RW-1:0] b);
        if (a[RW-1] == b[RW-1]) return a[RW-2:0] < b[RW-2:0];
        return a[RW-2:0] > b[RW-2:0];
    endfunction

    // p0 is hardwired ready; otherwise any matching writeback this cycle
    function automatic logic woken(input logic [PREG_WIDTH-1:0] p, input logic [WB_WIDTH-1:0] en,
                                   input logic [WB_WIDTH*PREG_WIDTH-1:0] prds);
        logic hit;
        hit = (p == '0);
        for (int j = 0; j < WB_WIDTH; j++)
            if (en[j] && prds[j*PREG_WIDTH +: PREG_WIDTH] == p) hit = 1'b1;
        return hit;
    endfunction

    assign full   = (CW'(DEPTH) - count) < CW'(IN_WIDTH);
    assign accept = ~full & ~redirect;

    // dispatch port i claims the i-th lowest-numbered free slot
    always_comb begin
        logic [CW-1:0] nfree;
        nfree = '0;
        for (int s = 0; s < DEPTH; s++) begin
            alloc_hit[s]  = 1'b0;
            alloc_port[s] = '0;
            if (!e_valid[s]) begin
                for (int i = 0; i < IN_WIDTH; i++)
                    if (accept && dis_en[i] && nfree == CW'(i)) begin
                        alloc_hit[s]  = 1'b1;
                        alloc_port[s] = PW'(i);
                    end
                nfree = nfree + 1'b1;
            end
        end
    end

    // rank each ready entry by age; rank k goes to port k only if that pipe is ready
    always_comb begin
        logic [CW-1:0] r;
        rdy      = e_valid & e_r1 & e_r2;
        iss_mask = '0;
        sel_v    = '0;
        for (int k = 0; k < OUT_WIDTH; k++) sel_i[k] = '0;
        for (int e = 0; e < DEPTH; e++) begin
            r = '0;
            for (int s = 0; s < DEPTH; s++)
                if (s != e && rdy[s] &&
                    (older(e_rob[s], e_rob[e]) || (e_rob[s] == e_rob[e] && s < e)))
                    r = r + 1'b1;
            rank[e] = r;
        end
        for (int e = 0; e < DEPTH; e++)
            for (int k = 0; k < OUT_WIDTH; k++)
                if (rdy[e] && rank[e] == CW'(k) && fu_ready[k] && !redirect) begin
                    sel_v[k]    = 1'b1;
                    sel_i[k]    = SW'(e);
                    iss_mask[e] = 1'b1;
                end
    end

    // surviving entries after flush, issue and allocation; count follows them
    always_comb begin
        nxt_valid = '0;
        nxt_count = '0;
        for (int s = 0; s < DEPTH; s++) begin
            if (redirect)
                nxt_valid[s] = e_valid[s] && !older(redirect_rob, e_rob[s]);
            else
                nxt_valid[s] = (e_valid[s] && !iss_mask[s]) || alloc_hit[s];
            nxt_count = nxt_count + CW'(nxt_valid[s]);
        end
    end

    // entry valid/ready state and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_valid <= '0;
            e_r1    <= '0;
            e_r2    <= '0;
            count   <= '0;
        end else begin
            e_valid <= nxt_valid;
            count   <= nxt_count;
            for (int s = 0; s < DEPTH; s++) begin
                if (alloc_hit[s]) begin
                    e_r1[s] <= dis_rs1v[alloc_port[s]] |
                               woken(dis_rs1[alloc_port[s]*PREG_WIDTH +: PREG_WIDTH], wb_en, wb_prd);
                    e_r2[s] <= dis_rs2v[alloc_port[s]] |
                               woken(dis_rs2[alloc_port[s]*PREG_WIDTH +: PREG_WIDTH], wb_en, wb_prd);
                end else begin
                    if (e_valid[s] && woken(e_rs1[s], wb_en, wb_prd)) e_r1[s] <= 1'b1;
                    if (e_valid[s] && woken(e_rs2[s], wb_en, wb_prd)) e_r2[s] <= 1'b1;
                end
            end
        end
    end

    // entry payload is only meaningful while valid, so it needs no reset
    always_ff @(posedge clk) begin
        for (int s = 0; s < DEPTH; s++)
            if (alloc_hit[s]) begin
                e_data[s] <= dis_data[alloc_port[s]*DATA_WIDTH +: DATA_WIDTH];
                e_rs1[s]  <= dis_rs1[alloc_port[s]*PREG_WIDTH +: PREG_WIDTH];
                e_rs2[s]  <= dis_rs2[alloc_port[s]*PREG_WIDTH +: PREG_WIDTH];
                e_prd[s]  <= dis_prd[alloc_port[s]*PREG_WIDTH +: PREG_WIDTH];
                e_rob[s]  <= dis_rob[alloc_port[s]*RW +: RW];
            end
    end

    // issue output registers; a redirect cycle selects nothing so every iss_en drops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_en   <= '0;
            iss_data <= '0;
            iss_prd  <= '0;
            iss_rob  <= '0;
        end else begin
            iss_en <= sel_v;
            for (int k = 0; k < OUT_WIDTH; k++)
                if (sel_v[k]) begin
                    iss_data[k*DATA_WIDTH +: DATA_WIDTH] <= e_data[sel_i[k]];
                    iss_prd[k*PREG_WIDTH +: PREG_WIDTH]  <= e_prd[sel_i[k]];
                    iss_rob[k*RW +: RW]                  <= e_rob[sel_i[k]];
                end
        end
    end

`ifdef INT_ISSUE_QUEUE_PERF_EN
    logic [32:0] full_sum, iss_sum;

    // next counter values with a carry bit used for saturation
    always_comb begin
        full_sum = {1'b0, perf_full_cycles} + 33'(full && (|dis_en));
        iss_sum  = {1'b0, perf_issue_cnt} + 33'($countones(sel_v));
    end

    // saturating counters, frozen during redirect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_full_cycles <= '0;
            perf_issue_cnt   <= '0;
        end else if (!redirect) begin
            perf_full_cycles <= full_sum[32] ? '1 : full_sum[31:0];
            perf_issue_cnt   <= iss_sum[32] ? '1 : iss_sum[31:0];
        end
    end
`endif
endmodule

// File: tb/tb_int_issue_queue.sv
// tb/tb_int_issue_queue.sv - self-checking bench for int_issue_queue
module tb_int_issue_queue;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   dis_en;
    logic [255:0] dis_data;
    logic [27:0]  dis_rs1, dis_rs2, dis_prd, dis_rob;
    logic [3:0]   dis_rs1v, dis_rs2v;
    logic         full;
    logic [3:0]   wb_en;
    logic [27:0]  wb_prd;
    logic [1:0]   iss_en;
    logic [127:0] iss_data;
    logic [13:0]  iss_prd, iss_rob;
    logic [1:0]   fu_ready;
    logic         redirect;
    logic [6:0]   redirect_rob;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int tag    = 0;

    typedef struct {
        int          cyc;
        int          port;
        logic [6:0]  rob;
        logic [63:0] data;
        logic [6:0]  prd;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [3:0][6:0] rob;
        logic [1:0]      fu0;
        logic [3:0]      port;
        logic [3:0][3:0] off;
    } vec_t;
    vec_t vecs[4];

    always #5 clk = ~clk;

    int_issue_queue dut (
        .clk(clk), .rst(rst),
        .dis_en(dis_en), .dis_data(dis_data), .dis_rs1(dis_rs1), .dis_rs2(dis_rs2),
        .dis_rs1v(dis_rs1v), .dis_rs2v(dis_rs2v), .dis_prd(dis_prd), .dis_rob(dis_rob),
        .full(full), .wb_en(wb_en), .wb_prd(wb_prd),
        .iss_en(iss_en), .iss_data(iss_data), .iss_prd(iss_prd), .iss_rob(iss_rob),
        .fu_ready(fu_ready), .redirect(redirect), .redirect_rob(redirect_rob)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clr();
        dis_en = '0; dis_data = '0; dis_rs1 = '0; dis_rs2 = '0; dis_prd = '0; dis_rob = '0;
        dis_rs1v = '0; dis_rs2v = '0; wb_en = '0; wb_prd = '0; redirect = 1'b0; redirect_rob = '0;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_iss(input int c, input int port, input logic [6:0] rob,
                              input logic [63:0] d, input logic [6:0] p);
        exp_t x;
        x.cyc = c; x.port = port; x.rob = rob; x.data = d; x.prd = p;
        sbq.push_back(x);
    endtask

    // drive dispatch port i; port >= 0 queues the expected issue at cyc+off
    task automatic op(input int i, input logic [6:0] rob, input logic [6:0] rs1, input logic v1,
                      input logic [6:0] rs2, input logic v2, input int port, input int off,
                      output logic [63:0] d, output logic [6:0] p);
        tag++;
        d = {32'hC0DE0000, 32'(tag)};
        p = 7'(tag + 16);
        dis_en[i] = 1'b1;
        dis_data[i*64 +: 64] = d;
        dis_rs1[i*7 +: 7] = rs1;  dis_rs1v[i] = v1;
        dis_rs2[i*7 +: 7] = rs2;  dis_rs2v[i] = v2;
        dis_prd[i*7 +: 7] = p;
        dis_rob[i*7 +: 7] = rob;
        if (port >= 0) expect_iss(cyc + off, port, rob, d, p);
    endtask

    task automatic set_vec(input int n, input logic [6:0] r0, input logic [6:0] r1, input logic [6:0] r2,
                           input logic [6:0] r3, input logic [1:0] fu, input logic [3:0] ports,
                           input int o0, input int o1, input int o2, input int o3);
        vecs[n].rob[0] = r0; vecs[n].rob[1] = r1; vecs[n].rob[2] = r2; vecs[n].rob[3] = r3;
        vecs[n].fu0 = fu; vecs[n].port = ports;
        vecs[n].off[0] = 4'(o0); vecs[n].off[1] = 4'(o1); vecs[n].off[2] = 4'(o2); vecs[n].off[3] = 4'(o3);
    endtask

    // scoreboard: every observed issue must match a queued expectation for this cycle/port
    always @(posedge clk) begin : mon
        int idx;
        int i;
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (iss_en[k]) begin
                idx = -1;
                for (int j = 0; j < sbq.size(); j++)
                    if (idx < 0 && sbq[j].cyc == cyc && sbq[j].port == k) idx = j;
                checks++;
                if (idx < 0) begin
                    errors++;
                    $display("FAIL unexpected_issue cyc=%0d port=%0d actual_rob=%0h required=none",
                             cyc, k, iss_rob[k*7 +: 7]);
                end else begin
                    if (iss_rob[k*7 +: 7] !== sbq[idx].rob || iss_data[k*64 +: 64] !== sbq[idx].data ||
                        iss_prd[k*7 +: 7] !== sbq[idx].prd) begin
                        errors++;
                        $display("FAIL issue_payload cyc=%0d port=%0d actual=%0h/%0h/%0h required=%0h/%0h/%0h",
                                 cyc, k, iss_rob[k*7 +: 7], iss_data[k*64 +: 64], iss_prd[k*7 +: 7],
                                 sbq[idx].rob, sbq[idx].data, sbq[idx].prd);
                    end
                    sbq.delete(idx);
                end
            end
        end
        i = 0;
        while (i < sbq.size()) begin
            if (sbq[i].cyc <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_issue cyc=%0d port=%0d rob=%0h actual=iss_en0 required=iss_en1",
                         sbq[i].cyc, sbq[i].port, sbq[i].rob);
                sbq.delete(i);
            end else begin
                i++;
            end
        end
    end

    initial begin
        logic [63:0] d;
        logic [6:0]  p;
        logic [63:0] fd[8];
        logic [6:0]  fp[8];
        int          base;

        set_vec(0, 7'h03, 7'h01, 7'h02, 7'h00, 2'b11, 4'b0011, 3, 2, 3, 2);
        set_vec(1, 7'h3E, 7'h41, 7'h3F, 7'h40, 2'b11, 4'b0110, 2, 3, 2, 3);
        set_vec(2, 7'h03, 7'h01, 7'h02, 7'h00, 2'b10, 4'b0110, 4, 2, 3, 3);
        set_vec(3, 7'h45, 7'h44, 7'h47, 7'h46, 2'b01, 4'b1000, 3, 2, 4, 3);

        rst = 1'b0; fu_ready = '0; clr();
        tick(); tick();
        check("rst_full", full, 0);
        check("rst_iss_en", iss_en, 0);
        check("rst_iss_data", iss_data, 0);
        check("rst_iss_prd", iss_prd, 0);
        check("rst_iss_rob", iss_rob, 0);
        rst = 1'b1;
        tick();

        // age-ordered select across orderings, ROB wrap and pipe backpressure
        for (int n = 0; n < 4; n++) begin
            fu_ready = vecs[n].fu0;
            for (int i = 0; i < 4; i++)
                op(i, vecs[n].rob[i], 7'd5, 1'b1, 7'd6, 1'b1, int'(vecs[n].port[i]), int'(vecs[n].off[i]), d, p);
            tick(); clr();
            tick(); fu_ready = 2'b11;
            repeat (4) tick();
        end

        // wakeup two cycles after insertion; rs2 is p0
        op(0, 7'h10, 7'd12, 1'b0, 7'd0, 1'b0, -1, 0, d, p);
        base = cyc;
        tick(); clr();
        tick(); wb_en[0] = 1'b1; wb_prd[6:0] = 7'd12;
        expect_iss(base + 4, 0, 7'h10, d, p);
        tick(); clr();
        repeat (4) tick();

        // wakeup in the insertion cycle
        op(0, 7'h11, 7'd3, 1'b1, 7'd9, 1'b0, 0, 2, d, p);
        wb_en[1] = 1'b1; wb_prd[13:7] = 7'd9;
        tick(); clr();
        repeat (4) tick();

        // fill to full with pipes stalled, then drain
        fu_ready = 2'b00;
        for (int i = 0; i < 4; i++) op(i, 7'(8'h20 + i), 7'd5, 1'b1, 7'd6, 1'b1, -1, 0, fd[i], fp[i]);
        tick(); clr();
        check("full_after_4", full, 0);
        for (int i = 0; i < 4; i++) op(i, 7'(8'h24 + i), 7'd5, 1'b1, 7'd6, 1'b1, -1, 0, fd[i+4], fp[i+4]);
        tick(); clr();
        check("full_after_8", full, 1);
        for (int i = 0; i < 4; i++) op(i, 7'(8'h28 + i), 7'd5, 1'b1, 7'd6, 1'b1, -1, 0, d, p);
        tick(); clr();
        check("full_held", full, 1);
        fu_ready = 2'b11;
        base = cyc;
        for (int j = 0; j < 4; j++) begin
            expect_iss(base + 1 + j, 0, 7'(8'h20 + 2*j), fd[2*j], fp[2*j]);
            expect_iss(base + 1 + j, 1, 7'(8'h21 + 2*j), fd[2*j+1], fp[2*j+1]);
        end
        tick();
        check("full_drain1", full, 1);
        tick();
        check("full_drain2", full, 0);
        repeat (4) tick();

        // reset mid-run with five entries parked
        fu_ready = 2'b00;
        for (int i = 0; i < 4; i++) op(i, 7'(8'h30 + i), 7'd5, 1'b1, 7'd6, 1'b1, -1, 0, d, p);
        tick(); clr();
        op(0, 7'h34, 7'd5, 1'b1, 7'd6, 1'b1, -1, 0, d, p);
        tick(); clr();
        check("prereset_full", full, 1);
        rst = 1'b0;
        #1;
        check("rstmid_full_async", full, 0);
        tick();
        check("rstmid_iss_en", iss_en, 0);
        rst = 1'b1;
        fu_ready = 2'b11;
        op(0, 7'h38, 7'd5, 1'b1, 7'd6, 1'b1, 0, 2, d, p);
        op(1, 7'h39, 7'd5, 1'b1, 7'd6, 1'b1, 1, 2, d, p);
        op(2, 7'h3A, 7'd5, 1'b1, 7'd6, 1'b1, 0, 3, d, p);
        op(3, 7'h3B, 7'd5, 1'b1, 7'd6, 1'b1, 1, 3, d, p);
        tick(); clr();
        repeat (4) tick();

        // redirect across a ROB wrap; equal entry survives, dispatch that cycle is dropped
        fu_ready = 2'b00;
        op(0, 7'h7E, 7'd5, 1'b1, 7'd6, 1'b1, -1, 0, fd[0], fp[0]);
        op(1, 7'h7F, 7'd5, 1'b1, 7'd6, 1'b1, -1, 0, fd[1], fp[1]);
        op(2, 7'h00, 7'd5, 1'b1, 7'd6, 1'b1, -1, 0, d, p);
        op(3, 7'h01, 7'd5, 1'b1, 7'd6, 1'b1, -1, 0, d, p);
        tick(); clr();
        redirect = 1'b1; redirect_rob = 7'h7F;
        op(0, 7'h05, 7'd5, 1'b1, 7'd6, 1'b1, -1, 0, d, p);
        tick(); clr();
        check("redir_full", full, 0);
        fu_ready = 2'b11;
        base = cyc;
        expect_iss(base + 1, 0, 7'h7E, fd[0], fp[0]);
        expect_iss(base + 1, 1, 7'h7F, fd[1], fp[1]);
        repeat (5) tick();

        check("scoreboard_empty", 128'(sbq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
